// File: rtl/mic1_microsequencer.sv
// mic1_microsequencer: MIC-1 control-store fetch/latch/execute sequencer with loader write port (optional MIC1_SEQ_STEP_EN single-step gate)
module mic1_microsequencer #(
    parameter logic [8:0] START_ADDR = 9'h000,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef MIC1_SEQ_STEP_EN
    input  logic             step,
`endif
    output logic             busy,
    output logic             halted,
    output logic [8:0]       mpc,
    output logic             cs_ren,
    output logic [8:0]       cs_raddr,
    input  logic [35:0]      cs_rdata,
    output logic             cs_wen,
    output logic [8:0]       cs_waddr,
    output logic [35:0]      cs_wdata,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [8:0]       ld_addr,
    input  logic [35:0]      ld_data,
    output logic [35:0]      mir,
    output logic             mir_valid,
    input  logic             dp_done,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic [7:0]       mbr,
    output logic [CNT_W-1:0] uinstr_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, HALT, STALL} state_t;
    state_t           state, state_n;
    logic [8:0]       mpc_n, nxt;
    logic [35:0]      mir_n;
    logic [CNT_W-1:0] cnt_n;
    logic             go, self_loop, idle_like;
`ifdef MIC1_SEQ_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif
    assign nxt       = {mir[35] | (mir[25] & alu_n) | (mir[24] & alu_z), mir[34:27] | (mir[26] ? mbr : 8'h00)};
    assign self_loop = ~|mir[26:24] && mir[35:27] == mpc;
    assign idle_like = state == IDLE || state == HALT;
    assign busy      = state == FETCH || state == LATCH || state == EXEC || state == STALL;
    assign halted    = state == HALT;
    assign mir_valid = state == EXEC;
    assign cs_ren    = state == FETCH;
    assign cs_raddr  = mpc;
    assign ld_ready  = idle_like & ~start;
    assign cs_wen    = ld_valid & ld_ready;
    assign cs_waddr  = ld_addr;
    assign cs_wdata  = ld_data;
    // next-state, next-mpc, MIR capture and completion counting
    always_comb begin
        state_n = state;
        mpc_n   = mpc;
        mir_n   = mir;
        cnt_n   = uinstr_cnt;
        case (state)
            IDLE, HALT: if (start) begin
                state_n = FETCH;
                mpc_n   = START_ADDR;
                cnt_n   = '0;
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                mir_n   = cs_rdata;
                state_n = EXEC;
            end
            EXEC: if (dp_done) begin
                cnt_n   = uinstr_cnt + CNT_W'(1);
                mpc_n   = self_loop ? mpc : nxt;
                state_n = self_loop ? HALT : (go ? FETCH : STALL);
            end
            STALL: state_n = go ? FETCH : STALL;
            default: state_n = IDLE;
        endcase
    end
    // sequencer state register, async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mpc        <= START_ADDR;
            mir        <= '0;
            uinstr_cnt <= '0;
        end else begin
            state      <= state_n;
            mpc        <= mpc_n;
            mir        <= mir_n;
            uinstr_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mic1_microsequencer.sv
// tb_mic1_microsequencer: vector table plus hand sequences, fetch-address scoreboard
module tb_mic1_microsequencer;
    logic        clk = 0, rst = 0, start = 0, ld_valid = 0, dp_done = 0, alu_n = 0, alu_z = 0;
    logic [8:0]  ld_addr = 0;
    logic [35:0] ld_data = 0;
    logic [7:0]  mbr = 0;
    logic [35:0] cs_rdata;
    logic        busy, halted, cs_ren, cs_wen, ld_ready, mir_valid;
    logic [8:0]  mpc, cs_raddr, cs_waddr;
    logic [35:0] cs_wdata, mir;
    logic [31:0] uinstr_cnt;
`ifdef MIC1_SEQ_STEP_EN
    logic        step = 1;
`endif
    int          checks = 0, failures = 0;
    logic [8:0]  sbq[$];
    logic [35:0] mem [512];

    mic1_microsequencer dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef MIC1_SEQ_STEP_EN
        .step(step),
`endif
        .busy(busy), .halted(halted), .mpc(mpc),
        .cs_ren(cs_ren), .cs_raddr(cs_raddr), .cs_rdata(cs_rdata),
        .cs_wen(cs_wen), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .mir(mir), .mir_valid(mir_valid), .dp_done(dp_done),
        .alu_n(alu_n), .alu_z(alu_z), .mbr(mbr), .uinstr_cnt(uinstr_cnt)
    );

    always #5 clk = ~clk;

    // control store model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (cs_wen) mem[cs_waddr] <= cs_wdata;
        if (cs_ren) cs_rdata <= mem[cs_raddr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard: every fetch must match the next expected address
    always @(negedge clk) begin
        if (cs_ren) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_unexpected: got %0h expected none", cs_raddr);
            end else chk("fetch_addr", cs_raddr, sbq.pop_front());
            chk("ren_wen_excl", cs_wen, 0);
        end
    end

    function automatic logic [35:0] mk(input logic [8:0] nx, input logic jm, jn, jz);
        return {nx, jm, jn, jz, 24'h0};
    endfunction

    task automatic load(input logic [8:0] a, input logic [35:0] d);
        int n = 0;
        ld_addr = a;
        ld_data = d;
        ld_valid = 1;
        #1;
        while (!cs_wen && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ld_accept", cs_wen, 1);
        @(posedge clk);
        #1 ld_valid = 0;
        @(negedge clk);
    endtask

    task automatic wait_mv();
        int n = 0;
        while (!mir_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mir_valid_wait", mir_valid, 1);
    endtask

    typedef struct {
        logic [35:0] word;
        logic        n, z;
        logic [7:0]  mbr;
        logic [8:0]  exp;
    } vec_t;
    vec_t vt[8];

    initial begin
        int bc;
        vt[0] = '{mk(9'h010, 0, 0, 1), 0, 1, 8'h00, 9'h110};
        vt[1] = '{mk(9'h010, 0, 0, 1), 1, 0, 8'h00, 9'h010};
        vt[2] = '{mk(9'h100, 1, 0, 0), 0, 0, 8'h3C, 9'h13C};
        vt[3] = '{mk(9'h020, 0, 1, 0), 1, 0, 8'h00, 9'h120};
        vt[4] = '{mk(9'h020, 0, 1, 0), 0, 1, 8'h00, 9'h020};
        vt[5] = '{mk(9'h000, 1, 0, 0), 1, 1, 8'hFF, 9'h0FF};
        vt[6] = '{mk(9'h1AB, 0, 1, 1), 1, 1, 8'h00, 9'h1AB};
        vt[7] = '{mk(9'h033, 0, 0, 0), 1, 1, 8'h55, 9'h033};
        rst = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mpc", mpc, 0);
        chk("rst_mir", mir, 0);
        chk("rst_mir_valid", mir_valid, 0);
        chk("rst_cnt", uinstr_cnt, 0);
        chk("rst_cs_ren", cs_ren, 0);
        chk("rst_cs_wen", cs_wen, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_ld_ready", ld_ready, 1);
        // next-address vectors, each ended by a reset pulse in the following EXEC
        for (int i = 0; i < 8; i++) begin
            load(0, vt[i].word);
            start = 1;
            sbq.push_back(0);
            @(negedge clk);
            start = 0;
            wait_mv();
            chk("vec_mir", mir, vt[i].word);
            alu_n = vt[i].n;
            alu_z = vt[i].z;
            mbr = vt[i].mbr;
            dp_done = 1;
            sbq.push_back(vt[i].exp);
            @(negedge clk);
            dp_done = 0;
            chk("vec_mpc", mpc, vt[i].exp);
            chk("vec_cnt", uinstr_cnt, 1);
            chk("vec_mir_valid_fall", mir_valid, 0);
            chk("vec_not_halted", halted, 0);
            wait_mv();
            #2 rst = 1;
            #1;
            chk("arst_busy", busy, 0);
            chk("arst_mir_valid", mir_valid, 0);
            chk("arst_mpc", mpc, 0);
            chk("arst_cnt", uinstr_cnt, 0);
            @(negedge clk);
            rst = 0;
        end
        // two-instruction program ending on a self-loop
        load(9'h000, mk(9'h005, 0, 0, 0));
        load(9'h005, mk(9'h005, 0, 0, 0));
        dp_done = 1;
        start = 1;
        sbq.push_back(9'h000);
        sbq.push_back(9'h005);
        @(negedge clk);
        start = 0;
        bc = 0;
        for (int i = 0; i < 20 && !halted; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        chk("halt_reached", halted, 1);
        chk("halt_busy_cycles", bc, 6);
        chk("halt_cnt", uinstr_cnt, 2);
        chk("halt_mpc", mpc, 9'h005);
        chk("halt_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        dp_done = 0;
        chk("halt_dp_done_ignored", uinstr_cnt, 2);
        chk("halt_mir_valid", mir_valid, 0);
        // restart from HALT with a colliding loader request, long datapath stall
        load(9'h000, 36'h0);
        ld_addr = 9'h1F0;
        ld_data = 36'hABCDE1234;
        ld_valid = 1;
        start = 1;
        #1;
        chk("start_wins_ready", ld_ready, 0);
        chk("start_wins_wen", cs_wen, 0);
        sbq.push_back(9'h000);
        @(negedge clk);
        start = 0;
        chk("restart_busy", busy, 1);
        chk("restart_cnt", uinstr_cnt, 0);
        chk("restart_mpc", mpc, 0);
        chk("busy_ld_ready", ld_ready, 0);
        wait_mv();
        for (int i = 0; i < 5; i++) begin
            chk("stall_mir_valid", mir_valid, 1);
            chk("stall_mpc", mpc, 0);
            chk("exec_no_wen", cs_wen, 0);
            start = (i == 2);
            @(negedge clk);
        end
        start = 0;
        dp_done = 1;
        @(negedge clk);
        dp_done = 0;
        chk("self_halt", halted, 1);
        chk("self_halt_cnt", uinstr_cnt, 1);
        chk("halt_ld_ready", ld_ready, 1);
        chk("halt_wen", cs_wen, 1);
        @(posedge clk);
        #1 ld_valid = 0;
        @(negedge clk);
        chk("halt_wen_once", cs_wen, 0);
        chk("halt_write_data", mem[9'h1F0], 36'hABCDE1234);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
